// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LEN_W  = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready register buffer. The head entry drives the output
// directly from flops; the second entry absorbs a push while the head stalls.
module stream_skid_buf
  import fifo_burst_pkg::*;
#(
  parameter int W = DEF_WIDTH + 1
) (
  input  logic             clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_space,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic         v1;
  logic [W-1:0] d1;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign occupancy = OCC_W'(out_valid) + OCC_W'(v1);
  assign in_space  = occupancy < OCC_W'(SKID_DEPTH);

  // Head/second-entry update: pops shift the second entry forward, pushes
  // fill the first free slot.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      v1        <= 1'b0;
      d1        <= '0;
    end else if (pop) begin
      if (v1) begin
        out_data <= d1;
        if (in_valid) begin
          d1 <= in_data;
        end else begin
          v1 <= 1'b0;
        end
      end else if (in_valid) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        d1 <= in_data;
        v1 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: on a length command, pops exactly that many tokens from a
// show-ahead FIFO and re-emits them on a registered valid/ready stream,
// tagging the final token with last and pulsing done once it has drained.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a burst command
// RUN   | popping while tokens remain, FIFO non-empty and buffer has room
// FLUSH | all tokens popped, waiting for the last one to leave the buffer
// DONE  | one-cycle done pulse with busy low, then back to IDLE
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             fifo_empty_n,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             buf_space;
  logic [OCC_W-1:0] buf_occ;
  logic [WIDTH:0]   buf_out;
  logic             cmd_accept;
  logic             pop;
  logic             pop_is_last;
  logic             last_hs;

  assign cmd_accept  = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign pop         = (state == ST_RUN) && fifo_empty_n && (remaining != '0) && buf_space;
  assign pop_is_last = (remaining == LEN_W'(1));
  assign fifo_read   = pop;
  assign last_hs     = m_valid && m_ready && m_last;
  assign m_last      = buf_out[WIDTH];
  assign m_data      = buf_out[WIDTH-1:0];

  stream_skid_buf #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (pop),
    .in_data   ({pop_is_last, fifo_dout}),
    .in_space  (buf_space),
    .out_valid (m_valid),
    .out_data  (buf_out),
    .out_ready (m_ready),
    .occupancy (buf_occ)
  );

  // Burst sequencing with registered handshake/status outputs. A zero-length
  // burst passes through FLUSH (buffer already empty) so its done pulse lands
  // two cycles after accept.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            remaining <= cmd_len;
            state     <= (cmd_len == '0) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pop) begin
            remaining <= remaining - LEN_W'(1);
            if (pop_is_last) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (last_hs || (buf_occ == '0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model feeding the DUT, per-burst
// scoreboard of expected tokens, table-driven and randomized bursts plus
// hand-written corner sequences.
module tb_fifo_burst_reader;

  localparam int TW = 16;
  localparam int TL = 5;

  logic          clk;
  logic          ap_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [TL-1:0] cmd_len;
  logic          fifo_empty_n;
  logic [TW-1:0] fifo_dout;
  logic          fifo_read;
  logic          m_valid;
  logic          m_ready;
  logic [TW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  fifo_burst_reader #(.WIDTH(TW), .LEN_W(TL)) dut (
    .clk          (clk),
    .ap_rst_n     (ap_rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .fifo_empty_n (fifo_empty_n),
    .fifo_dout    (fifo_dout),
    .fifo_read    (fifo_read),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [TW-1:0] fifo_q[$];
  logic [TW-1:0] model_q[$];
  bit            starve;

  int            g_pops, g_vcnt, g_rd_span, g_acc_cyc, g_done_cyc, g_hold_pops;
  logic [TW-1:0] g_hold_data;

  typedef struct {
    int len;
    int ready_pct;
    int starve_pct;
    int exp_pops;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    if (fifo_q.size() != 0 && !starve) begin
      fifo_empty_n = 1'b1;
      fifo_dout    = fifo_q[0];
    end else begin
      fifo_empty_n = 1'b0;
      fifo_dout    = TW'($urandom);
    end
  endtask

  task automatic push_tok(input logic [TW-1:0] v);
    fifo_q.push_back(v);
    model_q.push_back(v);
    drive_fifo();
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    model_q.delete();
    drive_fifo();
  endtask

  task automatic advance(input bit rd);
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fifo_q.size() != 0) fifo_q.delete(0);
    drive_fifo();
  endtask

  task automatic run_burst(input int len, input int ready_pct, input int starve_pct,
                           input int hold, input int starve_after, input int starve_len,
                           input bit keep_valid);
    logic [TW-1:0] exp_tok[$];
    bit            accepted, fin, last_seen, exp_done, rd;
    int            acc_cyc, hs_cyc, out_idx, pops, vcnt, st_cnt, first_rd, last_rd, n, budget;
    logic          pv, pr, pl;
    logic [TW-1:0] pd;
    accepted = 0; fin = 0; last_seen = 0; acc_cyc = 0; hs_cyc = 0;
    out_idx = 0; pops = 0; vcnt = 0; st_cnt = 0; first_rd = -1; last_rd = -1;
    pv = 0; pr = 0; pl = 0; pd = '0;
    for (int i = 0; i < len; i++)
      if (model_q.size() != 0) exp_tok.push_back(model_q.pop_front());
    cmd_len   = TL'(len);
    cmd_valid = 1'b1;
    m_ready   = 1'b1;
    starve    = 1'b0;
    drive_fifo();
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      advance(fifo_read);
    end
    chk("cmd_accept", 64'(accepted), 64'(1));
    if (!keep_valid) begin
      cmd_valid = 1'b0;
      cmd_len   = TL'($urandom);
    end
    budget = 20 * len + 100 + hold + starve_len;
    n = 0;
    while (!fin && n < budget) begin
      m_ready = (n < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (starve_len > 0) begin
        starve = (pops == starve_after) && (st_cnt < starve_len);
        if (starve) st_cnt++;
      end else begin
        starve = ($urandom_range(99) < starve_pct);
      end
      drive_fifo();
      @(negedge clk);
      rd = fifo_read;
      if (rd) begin
        chk("rd_only_when_nonempty", 64'(fifo_empty_n), 64'(1));
        pops++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (n == hold - 1) begin
        g_hold_pops = pops;
        g_hold_data = m_data;
      end
      exp_done = (len == 0) ? (cyc == acc_cyc + 2) : (last_seen && cyc == hs_cyc + 1);
      chk("done", 64'(done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(!exp_done));
      chk("cmd_ready_low_while_busy", 64'(cmd_ready), 64'(0));
      if (pv && !pr) chk("stall_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, pl, pd}));
      if (m_valid) vcnt++;
      if (m_valid && m_ready) begin
        if (out_idx < len) begin
          chk("m_data", 64'(m_data), 64'(exp_tok[out_idx]));
          chk("m_last", 64'(m_last), 64'(out_idx == len - 1));
          if (out_idx == len - 1) begin
            last_seen = 1;
            hs_cyc    = cyc;
          end
        end else begin
          chk("extra_token", 64'(out_idx), 64'(len));
        end
        out_idx++;
      end
      if (exp_done) begin
        fin        = 1;
        g_done_cyc = cyc;
      end
      pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
      advance(rd);
      n++;
    end
    chk("burst_finished", 64'(fin), 64'(1));
    chk("pops_per_burst", 64'(pops), 64'(len));
    chk("tokens_per_burst", 64'(out_idx), 64'(len));
    starve    = 1'b0;
    drive_fifo();
    g_pops    = pops;
    g_vcnt    = vcnt;
    g_acc_cyc = acc_cyc;
    g_rd_span = (first_rd >= 0) ? (last_rd - first_rd + 1) : 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int d1, p;
    bit ok;
    tbl[0] = '{1, 100, 0, 1};
    tbl[1] = '{2, 50, 0, 2};
    tbl[2] = '{5, 30, 30, 5};
    tbl[3] = '{7, 100, 50, 7};
    tbl[4] = '{16, 70, 20, 16};
    tbl[5] = '{0, 50, 0, 0};
    tbl[6] = '{3, 20, 10, 3};

    ap_rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b0; starve = 1'b0;
    drive_fifo();
    #12;
    chk("reset_outputs", 64'({cmd_ready, fifo_read, m_valid, m_last, m_data, busy, done}), 64'(0));
    @(posedge clk); #1;
    ap_rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_low_before_first_edge", 64'(cmd_ready), 64'(0));
    advance(1'b0);
    @(negedge clk);
    chk("cmd_ready_rises_after_reset", 64'(cmd_ready), 64'(1));
    advance(1'b0);

    // Nominal 4-token burst at full throughput.
    flush_fifo();
    push_tok(16'h000A); push_tok(16'h000B); push_tok(16'h000C); push_tok(16'h000D);
    run_burst(4, 100, 0, 0, -1, 0, 0);
    chk("nominal_rd_contiguous", 64'(g_rd_span), 64'(4));
    chk("nominal_valid_cycles", 64'(g_vcnt), 64'(4));

    // Backpressure: only two pops fit while m_ready is low.
    flush_fifo();
    for (int i = 0; i < 6; i++) push_tok(TW'(16'h0100 + i));
    run_burst(6, 100, 0, 8, -1, 0, 0);
    chk("backpressure_pops_held", 64'(g_hold_pops), 64'(2));
    chk("backpressure_head_token", 64'(g_hold_data), 64'(16'h0100));

    // Zero-length burst.
    run_burst(0, 100, 0, 0, -1, 0, 0);
    chk("zero_len_no_pop", 64'(g_pops), 64'(0));
    chk("zero_len_no_valid", 64'(g_vcnt), 64'(0));
    chk("zero_len_done_latency", 64'(g_done_cyc - g_acc_cyc), 64'(2));

    // Upstream starvation: one token, ten empty cycles, then the rest.
    flush_fifo();
    push_tok(16'h0201); push_tok(16'h0202); push_tok(16'h0203);
    run_burst(3, 100, 0, 0, 1, 10, 0);

    // Reset mid-burst after three pops.
    flush_fifo();
    for (int i = 0; i < 8; i++) push_tok(TW'(16'h0300 + i));
    m_ready = 1'b1; cmd_len = TL'(8); cmd_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      advance(fifo_read);
    end
    cmd_valid = 1'b0;
    p = 0;
    for (int k = 0; k < 20 && p < 3; k++) begin
      @(negedge clk);
      if (fifo_read) p++;
      advance(fifo_read);
    end
    chk("midburst_pops_before_reset", 64'(p), 64'(3));
    chk("midburst_valid_before_reset", 64'(m_valid), 64'(1));
    ap_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({cmd_ready, fifo_read, m_valid, m_last, m_data, busy, done}), 64'(0));
    @(negedge clk);
    advance(1'b0);
    ap_rst_n = 1'b1;
    @(negedge clk);
    chk("midburst_cmd_ready_low", 64'(cmd_ready), 64'(0));
    advance(1'b0);
    @(negedge clk);
    chk("midburst_cmd_ready_rise", 64'(cmd_ready), 64'(1));
    advance(1'b0);
    flush_fifo();
    push_tok(16'h0401); push_tok(16'h0402);
    run_burst(2, 100, 0, 0, -1, 0, 0);

    // Back-to-back commands with cmd_valid held.
    flush_fifo();
    push_tok(16'h0501); push_tok(16'h0502);
    run_burst(1, 100, 0, 0, -1, 0, 1);
    d1 = g_done_cyc;
    run_burst(1, 100, 0, 0, -1, 0, 1);
    chk("b2b_second_accept_after_done", 64'(g_acc_cyc), 64'(d1 + 1));
    cmd_valid = 1'b0;

    // Maximum length for the counter width.
    for (int i = 0; i < 31; i++) push_tok(TW'($urandom));
    run_burst(31, 80, 20, 0, -1, 0, 0);

    // Table-driven bursts.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tbl[t].len + int'($urandom_range(2)); i++) push_tok(TW'($urandom));
      run_burst(tbl[t].len, tbl[t].ready_pct, tbl[t].starve_pct, 0, -1, 0, 0);
      chk("table_pops", 64'(g_pops), 64'(tbl[t].exp_pops));
    end

    // Randomized bursts.
    for (int r = 0; r < 15; r++) begin
      int len;
      len = int'($urandom_range(12));
      for (int i = 0; i < len + int'($urandom_range(3)); i++) push_tok(TW'($urandom));
      run_burst(len, 20 + int'($urandom_range(80)), int'($urandom_range(50)), 0, -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
